// File: rtl/sum_display.sv
// Binary-to-BCD converter (double-dabble) with a 3-digit
// multiplexed seven-segment driver and leading-zero blanking.
module sum_display #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] sum,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [2:0] anode,
  output logic [6:0] segments
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_t;

  localparam logic [15:0] RLAST = 16'(REFRESH_DIV - 1);
  localparam logic [6:0]  BLANK = 7'b1111111;

  state_t      state, state_nxt;
  logic [19:0] shreg;
  logic [3:0]  iter;
  logic [3:0]  hun, ten, one;
  logic [3:0]  hun_nxt, ten_nxt, one_nxt;
  logic [15:0] rcnt;
  logic [1:0]  dig, dig_nxt;
  logic        rwrap;
  logic [2:0]  an_nxt;
  logic [6:0]  seg_nxt;

  function automatic logic [19:0] dabble(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (iter == 4'd7) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      iter  <= '0;
      hun   <= '0;
      ten   <= '0;
      one   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shreg <= {12'b0, sum};
            iter  <= '0;
          end
        end
        SHIFT: begin
          shreg <= dabble(shreg);
          iter  <= iter + 4'd1;
        end
        UPDATE: begin
          hun  <= hun_nxt;
          ten  <= ten_nxt;
          one  <= one_nxt;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Scan outputs are built from next-cycle values so they track the
  // digit index and display registers without an extra cycle of lag.
  always_comb begin
    rwrap   = (rcnt == RLAST);
    dig_nxt = dig;
    if (rwrap) dig_nxt = (dig == 2'd2) ? 2'd0 : dig + 2'd1;
    hun_nxt = (state == UPDATE) ? shreg[19:16] : hun;
    ten_nxt = (state == UPDATE) ? shreg[15:12] : ten;
    one_nxt = (state == UPDATE) ? shreg[11:8]  : one;
    an_nxt  = 3'b111;
    seg_nxt = BLANK;
    case (dig_nxt)
      2'd0: begin
        an_nxt  = 3'b110;
        seg_nxt = seg7(one_nxt);
      end
      2'd1: begin
        an_nxt = 3'b101;
        if (hun_nxt != 4'd0 || ten_nxt != 4'd0)
          seg_nxt = seg7(ten_nxt);
      end
      2'd2: begin
        an_nxt = 3'b011;
        if (hun_nxt != 4'd0) seg_nxt = seg7(hun_nxt);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt     <= '0;
      dig      <= '0;
      anode    <= 3'b110;
      segments <= 7'b1000000;
    end else begin
      rcnt     <= rwrap ? 16'd0 : rcnt + 16'd1;
      dig      <= dig_nxt;
      anode    <= an_nxt;
      segments <= seg_nxt;
    end
  end

endmodule
